// File: rtl/mem_arb_pkg.sv
// Shared types, default widths and helpers for the core memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DefAddrW = 8;
    localparam int unsigned DefDataW = 8;
    localparam int unsigned MaxCores = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } arb_state_e;

    // Width of a counter/index able to hold 0..n-1, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MaxCores-1:0] onehot(input int unsigned idx);
        return MaxCores'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: round-robin after 'last' by default,
// lowest index wins when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned IdxW      = idx_width(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [IdxW-1:0]      last_i,
    output logic [IdxW-1:0]      winner_o,
    output logic                 valid_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_i;

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (!valid_o && req_i[k]) begin
                valid_o  = 1'b1;
                winner_o = IdxW'(k);
            end
        end
    end
`else
    logic [IdxW-1:0] cand;

    // Walk from last+1 with wrap; the first requester seen wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        cand     = last_i;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            cand = (cand == IdxW'(NUM_CORES - 1)) ? '0 : cand + IdxW'(1);
            if (!valid_o && req_i[cand]) begin
                valid_o  = 1'b1;
                winner_o = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one data memory between NUM_CORES cores, one transaction at a time.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module core_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned MEM_LAT   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        grant,
    output logic [NUM_CORES-1:0]        done,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int unsigned IdxW = idx_width(NUM_CORES);
    localparam int unsigned LatW = idx_width(MEM_LAT);

    arb_state_e           state_q, state_d;
    logic [NUM_CORES-1:0] grant_q, grant_d;
    logic [NUM_CORES-1:0] done_q, done_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic [LatW-1:0]      lat_cnt_q, lat_cnt_d;
    logic [IdxW-1:0]      last_q, last_d;

    logic [IdxW-1:0]      pick_idx;
    logic                 pick_valid;

    rr_pick #(
        .NUM_CORES (NUM_CORES),
        .IdxW      (IdxW)
    ) u_rr_pick (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (pick_idx),
        .valid_o  (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        rdata_d     = rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lat_cnt_d   = lat_cnt_q;
        last_d      = last_q;

        unique case (state_q)
            StIdle: begin
                // Core inputs are captured only here and then held for the whole access.
                if (pick_valid) begin
                    grant_d     = NUM_CORES'(onehot(32'(pick_idx)));
                    mem_en_d    = 1'b1;
                    mem_we_d    = we[pick_idx];
                    mem_addr_d  = addr[pick_idx*ADDR_W +: ADDR_W];
                    mem_wdata_d = wdata[pick_idx*DATA_W +: DATA_W];
                    lat_cnt_d   = LatW'(MEM_LAT - 1);
                    last_d      = pick_idx;
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (lat_cnt_q == '0) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    done_d   = grant_q;
                    state_d  = StDone;
                end else begin
                    lat_cnt_d = lat_cnt_q - LatW'(1);
                end
            end
            StDone: begin
                grant_d = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lat_cnt_q   <= '0;
            last_q      <= IdxW'(NUM_CORES - 1);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lat_cnt_q   <= lat_cnt_d;
            last_q      <= last_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: transaction-level model checked every cycle plus directed literals.
module tb_core_mem_arbiter;

    localparam int NC  = 4;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NC-1:0]     req = '0;
    logic [NC-1:0]     we = '0;
    logic [NC*AW-1:0]  addr = '0;
    logic [NC*DW-1:0]  wdata = '0;
    logic [NC-1:0]     grant;
    logic [NC-1:0]     done;
    logic [DW-1:0]     rdata;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    core_mem_arbiter #(
        .NUM_CORES (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .grant     (grant),
        .done      (done),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Shared RAM: unwritten locations return a fixed pattern, 0x22 holds 0xA5.
    logic [DW-1:0] mem [256];
    bit            written [256];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 8'h22) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return written[a] ? mem[a] : init_val(a);
    endfunction

    assign mem_rdata = written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    // Model: m_phase counts cycles since the grant edge (0 = idle).
    int            m_phase = 0;
    int            m_last = NC - 1;
    int            m_g = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;

    function automatic int pick(input logic [NC-1:0] r, input int last);
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NC; k++) begin
            if (1'(r >> k)) return k;
        end
        return (last < 0) ? -2 : -1;
`else
        for (int k = 1; k <= NC; k++) begin
            if (1'(r >> ((last + k) % NC))) return (last + k) % NC;
        end
        return -1;
`endif
    endfunction

    task automatic model_step();
        if (rst) begin
            m_phase = 0;
            m_last  = NC - 1;
            m_we    = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
            m_rdata = '0;
        end else if (m_phase == 0) begin
            if (req != '0) begin
                m_g     = pick(req, m_last);
                m_last  = m_g;
                m_we    = we[m_g];
                m_addr  = addr[m_g*AW +: AW];
                m_wdata = wdata[m_g*DW +: DW];
                m_phase = 1;
            end
        end else if (m_phase == LAT) begin
            if (!m_we) m_rdata = mem_val(m_addr);
            m_phase = LAT + 1;
        end else if (m_phase == LAT + 1) begin
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : cmp
        logic [NC-1:0] eg;
        logic          een;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                eg  = (m_phase != 0) ? (NC'(1) << m_g) : '0;
                een = (m_phase >= 1) && (m_phase <= LAT);
                check("m_grant", 32'(grant), 32'(eg));
                check("m_done", 32'(done), (m_phase == LAT + 1) ? 32'(eg) : 32'd0);
                check("m_rdata", 32'(rdata), 32'(m_rdata));
                check("m_mem_en", 32'(mem_en), 32'(een));
                check("m_mem_we", 32'(mem_we), 32'(een && m_we));
                check("m_mem_addr", 32'(mem_addr), 32'(m_addr));
                check("m_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            end
        end
    end

    task automatic set_core(input int c, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        we[c]             = w;
        addr[c*AW +: AW]  = a;
        wdata[c*DW +: DW] = d;
    endtask

    // Starts at a negedge; returns the granted core at the negedge where done is seen.
    task automatic serve(output int g);
        int n;
        n = 0;
        g = -1;
        @(negedge clk);
        while (grant == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < NC; k++) begin
            if (grant[k]) g = k;
        end
        while (done == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done != '0), 32'd1);
    endtask

    int g;
    int exp_order [5];

    initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_on = 1'b1;
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);

        // Single read by core 1.
        rst = 1'b0;
        set_core(1, 1'b0, 8'h22, 8'h00);
        req = 4'b0010;
        @(negedge clk);
        check("rd_grant", 32'(grant), 32'h2);
        check("rd_mem_en", 32'(mem_en), 32'd1);
        check("rd_mem_addr", 32'(mem_addr), 32'h22);
        @(negedge clk);
        check("rd_mem_en2", 32'(mem_en), 32'd1);
        check("rd_grant2", 32'(grant), 32'h2);
        @(negedge clk);
        check("rd_done", 32'(done), 32'h2);
        check("rd_rdata", 32'(rdata), 32'hA5);
        check("rd_grant3", 32'(grant), 32'h2);
        check("rd_mem_en3", 32'(mem_en), 32'd0);
        req = '0;
        @(negedge clk);
        check("rd_done_clr", 32'(done), 32'd0);
        check("rd_grant_clr", 32'(grant), 32'd0);

        // Single write by core 3.
        set_core(3, 1'b1, 8'h10, 8'h3C);
        req = 4'b1000;
        @(negedge clk);
        check("wr_grant", 32'(grant), 32'h8);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_wdata", 32'(mem_wdata), 32'h3C);
        check("wr_mem_addr", 32'(mem_addr), 32'h10);
        @(negedge clk);
        check("wr_mem_we2", 32'(mem_we), 32'd1);
        @(negedge clk);
        check("wr_done", 32'(done), 32'h8);
        check("wr_rdata_kept", 32'(rdata), 32'hA5);
        req = '0;
        @(negedge clk);

        // Wrap: last is 3, cores 0 and 3 request.
        set_core(0, 1'b0, 8'h40, 8'h00);
        set_core(3, 1'b0, 8'h41, 8'h00);
        req = 4'b1001;
        serve(g);
        check("wrap_first", 32'(g), 32'd0);
        req[0] = 1'b0;
        serve(g);
        check("wrap_second", 32'(g), 32'd3);
        req = '0;
        @(negedge clk);

        // Contention held from reset release.
        rst = 1'b1;
        for (int k = 0; k < NC; k++) set_core(k, 1'b0, AW'(8'h50 + k), 8'h00);
        req = 4'b1111;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            serve(g);
            check("contend_order", 32'(g), 32'(exp_order[i]));
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Core 2 drops req and changes addr mid-access.
        set_core(2, 1'b0, 8'h05, 8'h00);
        req = 4'b0100;
        @(negedge clk);
        check("drop_grant", 32'(grant), 32'h4);
        check("drop_addr", 32'(mem_addr), 32'h05);
        req = '0;
        set_core(2, 1'b1, 8'hFF, 8'h99);
        @(negedge clk);
        check("drop_addr_held", 32'(mem_addr), 32'h05);
        check("drop_we_held", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("drop_done", 32'(done), 32'h4);
        @(negedge clk);

        // Reset on the first access cycle of a write.
        set_core(1, 1'b1, 8'h60, 8'h77);
        req = 4'b0010;
        @(negedge clk);
        check("abort_grant", 32'(grant), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        check("abort_grant_clr", 32'(grant), 32'd0);
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        check("abort_restart", 32'(grant), 32'h1);
        check("abort_no_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
